// File: rtl/cpu_run_controller_if.sv
// Board/CPU-facing signal bundle for cpu_run_controller.
// master = board I/O and CPU side, slave = the run controller.
interface cpu_run_controller_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             run_sw;
  logic             step_key_n;
  logic             instr_done;
  logic [PC_W-1:0]  pc;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic             cpu_en;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run_sw, step_key_n, instr_done, pc, bp_en, bp_addr,
    input  cpu_en, halted, state, instr_count
  );

  modport slave (
    input  run_sw, step_key_n, instr_done, pc, bp_en, bp_addr,
    output cpu_en, halted, state, instr_count
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer producing the CPU clock enable; stops only on instruction boundaries.
// Define CPU_RUN_CTRL_BREAKPOINT_EN to enable the PC breakpoint compare and the BREAK state.
module cpu_run_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PC_W            = 8,
  parameter int CNT_W           = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  cpu_run_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    st_halt  = 2'd0,
    st_run   = 2'd1,
    st_step  = 2'd2,
    st_break = 2'd3
  } state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  // Lane 0 = run switch (idle 0), lane 1 = step key (idle 1, released).
  localparam logic [1:0] LANE_IDLE = 2'b10;

  logic [1:0]       raw_s;
  logic [1:0]       meta_r;
  logic [1:0]       sync_r;
  logic [1:0]       db_r;
  logic [DB_W-1:0]  db_cnt_r [2];
  logic             key_db_d_r;
  logic             run_db_s;
  logic             step_pulse_s;
  logic             bp_hit_s;
  state_t           state_r;
  state_t           next_state_s;
  logic             cpu_en_r;
  logic             halted_r;
  logic [CNT_W-1:0] instr_count_r;

  assign raw_s        = {bus.step_key_n, bus.run_sw};
  assign run_db_s     = db_r[0];
  assign step_pulse_s = key_db_d_r & ~db_r[1];

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  assign bp_hit_s = bus.bp_en & (bus.pc == bus.bp_addr);
`else
  logic bp_unused_s;
  assign bp_hit_s    = 1'b0;
  assign bp_unused_s = ^{bus.bp_en, bus.bp_addr, bus.pc};
`endif

  // Synchronise both raw inputs and accept a change only after it has held DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r     <= LANE_IDLE;
      sync_r     <= LANE_IDLE;
      db_r       <= LANE_IDLE;
      key_db_d_r <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      meta_r     <= raw_s;
      sync_r     <= meta_r;
      key_db_d_r <= db_r[1];
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] != db_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            db_r[i]     <= sync_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Next-state rules; RUN and STEP only leave on an instruction boundary.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      st_halt: begin
        if (run_db_s) begin
          next_state_s = st_run;
        end else if (step_pulse_s) begin
          next_state_s = st_step;
        end else begin
          next_state_s = st_halt;
        end
      end
      st_run: begin
        if (bus.instr_done) begin
          if (!run_db_s) begin
            next_state_s = st_halt;
          end else if (bp_hit_s) begin
            next_state_s = st_break;
          end else begin
            next_state_s = st_run;
          end
        end else begin
          next_state_s = st_run;
        end
      end
      st_step: begin
        if (bus.instr_done) begin
          next_state_s = st_halt;
        end else begin
          next_state_s = st_step;
        end
      end
      st_break: begin
        if (!run_db_s) begin
          next_state_s = st_halt;
        end else if (step_pulse_s) begin
          next_state_s = st_step;
        end else begin
          next_state_s = st_break;
        end
      end
      default: next_state_s = st_halt;
    endcase
  end

  // State register with Moore outputs decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= st_halt;
      cpu_en_r <= 1'b0;
      halted_r <= 1'b1;
    end else begin
      state_r  <= next_state_s;
      cpu_en_r <= (next_state_s == st_run) || (next_state_s == st_step);
      halted_r <= !((next_state_s == st_run) || (next_state_s == st_step));
    end
  end

  // Retired-instruction counter; only reset clears it, halting does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_r <= '0;
    end else if (cpu_en_r && bus.instr_done) begin
      instr_count_r <= instr_count_r + CNT_W'(1);
    end else begin
      instr_count_r <= instr_count_r;
    end
  end

  assign bus.cpu_en      = cpu_en_r;
  assign bus.halted      = halted_r;
  assign bus.state       = state_r;
  assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: directed vector table plus randomized run against a reference model.
// Honours CPU_RUN_CTRL_BREAKPOINT_EN in its expectations.
module tb_cpu_run_controller;

  localparam int DB    = 4;
  localparam int PC_W  = 8;
  localparam int CNT_W = 4;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  cpu_run_controller_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  cpu_run_controller #(.DEBOUNCE_CYCLES(DB), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 halt, 1 run, 2 step, 3 break.
  int m_mode;
  int m_cnt;
  bit m_run_db;
  bit m_key_db;
  bit m_key_prev;
  int m_run_len;
  int m_key_len;
  bit run_hist[$];
  bit key_hist[$];

  task automatic model_reset();
    m_mode     = 0;
    m_cnt      = 0;
    m_run_db   = 1'b0;
    m_key_db   = 1'b1;
    m_key_prev = 1'b1;
    m_run_len  = 0;
    m_key_len  = 0;
    run_hist   = {1'b0, 1'b0};
    key_hist   = {1'b1, 1'b1};
  endtask

  task automatic model_step();
    bit run_seen;
    bit key_seen;
    bit press;
    bit hit;
    bit running;
    run_seen = run_hist[1];
    key_seen = key_hist[1];
    press    = m_key_prev && !m_key_db;
    hit      = BP && bus.bp_en && (bus.pc == bus.bp_addr);
    running  = (m_mode == 1) || (m_mode == 2);
    if (running && bus.instr_done) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    case (m_mode)
      0: if (m_run_db) m_mode = 1; else if (press) m_mode = 2;
      1: if (bus.instr_done) begin
           if (!m_run_db) m_mode = 0; else if (hit) m_mode = 3;
         end
      2: if (bus.instr_done) m_mode = 0;
      3: if (!m_run_db) m_mode = 0; else if (press) m_mode = 2;
      default: m_mode = 0;
    endcase
    m_key_prev = m_key_db;
    m_run_len  = (run_seen != m_run_db) ? m_run_len + 1 : 0;
    if (m_run_len == DB) begin m_run_db = run_seen; m_run_len = 0; end
    m_key_len  = (key_seen != m_key_db) ? m_key_len + 1 : 0;
    if (m_key_len == DB) begin m_key_db = key_seen; m_key_len = 0; end
    run_hist.push_front(bus.run_sw);
    void'(run_hist.pop_back());
    key_hist.push_front(bus.step_key_n);
    void'(key_hist.pop_back());
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    bit en;
    @(posedge clk);
    model_step();
    #1;
    en = (m_mode == 1) || (m_mode == 2);
    check("model state", int'(bus.state), m_mode);
    check("model cpu_en", int'(bus.cpu_en), int'(en));
    check("model halted", int'(bus.halted), int'(!en));
    check("model count", int'(bus.instr_count), m_cnt);
  endtask

  typedef struct {
    int         n;
    bit         run;
    bit         key_n;
    bit         done;
    logic [7:0] pc;
    int         st;
    bit         en;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.run_sw     = 1'b0;
    bus.step_key_n = 1'b1;
    bus.instr_done = 1'b0;
    bus.pc         = 8'h00;
    bus.bp_en      = 1'b1;
    bus.bp_addr    = 8'h10;

    // n, run, key_n, done, pc, expected state, cpu_en, count
    vecs.push_back('{6, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 0});  // debounce not yet done
    vecs.push_back('{1, 1'b1, 1'b1, 1'b0, 8'h00, 1, 1'b1, 0});  // 7th cycle: RUN
    vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b1, 0});  // short glitch
    vecs.push_back('{6, 1'b1, 1'b1, 1'b0, 8'h00, 1, 1'b1, 0});
    vecs.push_back('{6, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b1, 0});  // debounced drop
    vecs.push_back('{4, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b1, 0});  // deferred stop
    vecs.push_back('{1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1});  // boundary -> HALT
    vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1});
    vecs.push_back('{6, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1});  // key press debouncing
    vecs.push_back('{1, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b1, 1});  // STEP
    vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b1, 1});
    vecs.push_back('{1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 2});  // retire after 3 cycles
    vecs.push_back('{8, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 2});  // release: no step
    vecs.push_back('{7, 1'b1, 1'b1, 1'b0, 8'h00, 1, 1'b1, 2});
    vecs.push_back('{1, 1'b1, 1'b1, 1'b1, 8'h0E, 1, 1'b1, 3});
    vecs.push_back('{1, 1'b1, 1'b1, 1'b1, 8'h0F, 1, 1'b1, 4});
    vecs.push_back('{1, 1'b1, 1'b1, 1'b1, 8'h10, BP ? 3 : 1, !BP, 5});  // breakpoint
    vecs.push_back('{1, 1'b1, 1'b1, 1'b0, 8'h10, BP ? 3 : 1, !BP, 5});
    vecs.push_back('{7, 1'b1, 1'b0, 1'b0, 8'h10, BP ? 2 : 1, 1'b1, 5});  // step from BREAK
    vecs.push_back('{1, 1'b1, 1'b0, 1'b1, 8'h10, BP ? 0 : 1, !BP, 6});
    vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 8'h10, 1, 1'b1, 6});           // RUN wins in HALT
    vecs.push_back('{7, 1'b0, 1'b1, 1'b1, 8'h20, 0, 1'b0, 13});
    vecs.push_back('{7, 1'b1, 1'b1, 1'b0, 8'h20, 1, 1'b1, 13});
    vecs.push_back('{3, 1'b1, 1'b1, 1'b1, 8'h20, 1, 1'b1, 0});           // wrap 15 -> 0
    vecs.push_back('{1, 1'b1, 1'b1, 1'b1, 8'h20, 1, 1'b1, 1});
    vecs.push_back('{7, 1'b0, 1'b1, 1'b0, 8'h20, 1, 1'b1, 1});
    vecs.push_back('{1, 1'b0, 1'b1, 1'b1, 8'h20, 0, 1'b0, 2});
    vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 8'h20, 0, 1'b0, 2});           // done in HALT ignored
    vecs.push_back('{7, 1'b0, 1'b0, 1'b0, 8'h20, 2, 1'b1, 2});           // enter STEP

    repeat (3) @(negedge clk);
    check("reset state", int'(bus.state), 0);
    check("reset cpu_en", int'(bus.cpu_en), 0);
    check("reset halted", int'(bus.halted), 1);
    check("reset count", int'(bus.instr_count), 0);
    model_reset();
    rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      bus.run_sw     = vecs[r].run;
      bus.step_key_n = vecs[r].key_n;
      bus.instr_done = vecs[r].done;
      bus.pc         = vecs[r].pc;
      for (int k = 0; k < vecs[r].n; k++) tick();
      check($sformatf("row%0d state", r), int'(bus.state), vecs[r].st);
      check($sformatf("row%0d cpu_en", r), int'(bus.cpu_en), int'(vecs[r].en));
      check($sformatf("row%0d halted", r), int'(bus.halted), int'(!vecs[r].en));
      check($sformatf("row%0d count", r), int'(bus.instr_count), vecs[r].cnt);
    end

    // Asynchronous reset in the middle of a step, checked before the next clock edge.
    #2;
    rst_n = 1'b0;
    bus.step_key_n = 1'b1;
    #1;
    check("async rst state", int'(bus.state), 0);
    check("async rst cpu_en", int'(bus.cpu_en), 0);
    check("async rst halted", int'(bus.halted), 1);
    check("async rst count", int'(bus.instr_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(11, 0) == 0) bus.run_sw = ~bus.run_sw;
      if ($urandom_range(9, 0) == 0) bus.step_key_n = ~bus.step_key_n;
      bus.instr_done = ($urandom_range(2, 0) == 0);
      bus.pc         = 8'h0E + 8'($urandom_range(3, 0));
      if ($urandom_range(99, 0) == 0) bus.bp_en = ~bus.bp_en;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Run/halt/single-step sequencer for the MyComputer CPU core. Turns the board run switch (SW[9]) and a step pushbutton (KEY) into a clock-enable for the CPU datapath, stopping only on instruction boundaries. Sits between the board I/O and the CPU's enable input; exposes state and a retired-instruction count for LEDR/HEX display.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles before a switch/key change is accepted (10 ms at 50 MHz)
PC_W, 8, width of CPU program counter
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
run_sw  input  1  raw run switch; 1 = run, 0 = halt
step_key_n  input  1  raw step pushbutton, active-low
instr_done  input  1  CPU pulse: instruction retires on this clk edge when cpu_en=1
pc  input  PC_W  address of instruction retiring while instr_done=1
bp_en  input  1  breakpoint enable
bp_addr  input  PC_W  breakpoint address
cpu_en  output  1  CPU clock enable
halted  output  1  1 when cpu_en=0
state  output  2  FSM state code for LEDs
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=HALT, cpu_en=0, halted=1, state=2'd0, instr_count=0, synchronisers and debouncers cleared to run=0 and key released; applies immediately, including mid-instruction.
- Input conditioning: run_sw and step_key_n each pass through a 2-FF synchroniser, then a debouncer.
  - Debounced value takes the synchronised value only after it differs from the current debounced value for DEBOUNCE_CYCLES consecutive cycles.
  - A shorter glitch resets the count and is ignored.
- step_pulse: one-cycle pulse on the debounced key 1->0 edge (press). Release generates nothing.
- FSM states (code): HALT=0, RUN=1, STEP=2, BREAK=3. Outputs are Moore: cpu_en=1 in RUN and STEP only; halted=!cpu_en.
- HALT:
  - run_db=1 -> RUN.
  - else step_pulse -> STEP.
- RUN: on a cycle with instr_done=1:
  - run_db=0 -> HALT.
  - else bp hit -> BREAK.
  - bp hit = bp_en=1 and pc==bp_addr.
  - With instr_done=0, stay in RUN even if run_db=0; the stop is deferred to the instruction boundary.
- STEP: stays until instr_done=1, then -> HALT. run_db and breakpoint are ignored during STEP; a step always completes exactly one instruction.
- BREAK:
  - run_db=0 -> HALT; the switch must be cycled off/on to resume.
  - step_pulse -> STEP.
  - run_db staying 1 keeps BREAK.
- Latency: the transition is taken on the clk edge where instr_done=1. cpu_en is 0 from the next cycle, so no further instruction starts.
- Start latency: cpu_en rises 1 cycle after the debounced run level or step_pulse.
- instr_count increments on every edge with cpu_en=1 and instr_done=1, and wraps all-ones -> 0. It is not cleared by halt, only by reset.
- Simultaneous events:
  - step_pulse while run_db=1 in HALT: RUN wins.
  - instr_done while in HALT/BREAK is ignored and not counted.

Optional Feature:
CPU_RUN_CTRL_BREAKPOINT_EN
- Defined: breakpoint compare and BREAK state as described.
- Undefined:
  - bp_en/bp_addr are ignored (ports remain).
  - bp hit is constant 0.
  - BREAK is unreachable; state never reads 3.
  - RUN leaves only via run_db=0 at an instruction boundary.

Test Plan:
(Sim with DEBOUNCE_CYCLES=4.)
- Reset then run_sw=1 held 10 cycles -> cpu_en=1 seven cycles after the switch edge (2 sync + 4 debounce + 1 state), state=1. Pulse run_sw 1->0 for 2 cycles only -> no change.
- HALT, press step_key_n low 8 cycles, CPU model retires after 3 enabled cycles -> cpu_en high exactly 3 cycles, state returns 0, instr_count=1. Release key -> no second step.
- RUN, drop run_sw, instr_done arrives 5 cycles after the debounced drop -> cpu_en stays 1 until that edge, then 0. instr_count counts that instruction.
- RUN with bp_en=1, bp_addr=8'h10, retire pc 0x0E, 0x0F, 0x10 -> state=3 after 0x10, cpu_en=0, count +3. Step press -> one instruction then HALT. run_sw off/on -> RUN.
- Preload by running 65535 retirements (or force CNT_W=4 with 15) then one more -> instr_count wraps to 0.
- Assert rst_n=0 mid-STEP with cpu_en=1 -> cpu_en=0 and state=0 immediately (before next clk edge). instr_count=0.
